aes_result_monitor: RTL and testbench
=====================================

# aes_result_monitor

Downstream consumer of the SPI AES master. It edge-detects the master's encrypt-done and decrypt-done pulses and captures the 128-bit result bus at each one. After a full encrypt/decrypt pair it compares both results against expected vectors, keeps saturating pass/fail counters, and streams a 34-byte result packet over a byte-wide valid/ready port toward a UART/debug sink. It runs on the master's undivided clock.

## Interface
- CNT_W, 16, width of pass/fail counters
- STREAM_EN, 1, 1 = emit result packet after each compare; 0 = skip streaming
- clk  in  1  system clock (master's undivided clock)
- rst  in  1  reset; asynchronous, active-high
- enc_done  in  1  encrypt-done level pulse from master; held ≥1 clk, may be held many clk
- dec_done  in  1  decrypt-done level pulse from master; same rules as enc_done
- data_out  in  128  master result bus; valid while the corresponding done is high
- exp_enc  in  128  expected ciphertext; sampled at the enc_done rising edge
- exp_dec  in  128  expected decrypt output; sampled at the dec_done rising edge
- cipher_q  out  128  captured encrypt result
- dec_q  out  128  captured decrypt result
- match  out  1  one-cycle pulse: both captures equal their expected values
- mismatch  out  1  one-cycle pulse: at least one capture differs
- pass_cnt  out  CNT_W  count of match pulses; saturates at all-ones
- fail_cnt  out  CNT_W  count of mismatch pulses; saturates at all-ones
- overrun  out  1  sticky: enc_done edge arrived outside IDLE
- orphan  out  1  sticky: dec_done edge arrived outside WAIT_DEC
- busy  out  1  high whenever the FSM is not in IDLE
- tx_data  out  8  packet byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data

## Operation
- Edge detect: enc_prev/dec_prev registers.
  - enc_rise = enc_done & ~enc_prev.
  - dec_rise = dec_done & ~dec_prev.
  - A held level produces exactly one event.
- FSM states: IDLE, WAIT_DEC, COMPARE, STREAM.
- IDLE + enc_rise:
  - cipher_q <= data_out.
  - exp_enc is registered internally.
  - Next state WAIT_DEC.
- WAIT_DEC + dec_rise:
  - dec_q <= data_out.
  - exp_dec is registered internally.
  - Next state COMPARE.
- COMPARE:
  - Pulse match or mismatch.
  - Increment the matching counter unless it is saturated.
  - Next state is STREAM if STREAM_EN, otherwise IDLE.
- STREAM sends 34 bytes in this order:
  - Header 0xA5.
  - Status byte {5'b0, overrun, orphan, match_flag}.
  - cipher_q bytes [127:120] down to [7:0].
  - dec_q bytes in the same order.
  - After the last byte is accepted, next state IDLE.
- Error events:
  - enc_rise in WAIT_DEC, COMPARE or STREAM: set overrun, ignore the capture, no state change.
  - dec_rise in IDLE, COMPARE or STREAM: set orphan, ignore the capture.
- Simultaneous enc_rise and dec_rise:
  - In IDLE: take enc, set orphan.
  - In WAIT_DEC: take dec, set overrun.
- Sticky flags clear only on rst.
- Any state + rst: return to IDLE immediately.
- Reset values:
  - All outputs 0.
  - Captures 0, counters 0, flags 0.
  - tx_valid 0.
  - enc_prev and dec_prev 0.

## Timing
- Capture timing: data_out is captured on the same clk edge where enc_done or dec_done is first sampled high. cipher_q/dec_q are valid the following cycle.
- match/mismatch:
  - Asserted in the cycle after the dec capture edge (the COMPARE cycle), for exactly one cycle.
  - Counters update at the end of that cycle.
- tx_valid rises the cycle after COMPARE.
- Handshake:
  - A byte transfers on a clk edge where tx_valid & tx_ready.
  - While tx_valid & ~tx_ready, tx_data is held stable.
  - tx_valid never drops mid-packet.
- With tx_ready tied high:
  - STREAM lasts exactly 34 cycles.
  - busy falls the cycle after the 34th transfer.
- Minimum turnaround from enc_rise to the next accepted enc_rise:
  - 3 + 34 cycles with STREAM_EN=1.
  - 3 cycles with STREAM_EN=0.
- Status byte content: snapshots the flag values at COMPARE, so flags set during STREAM do not alter the in-flight packet.

## Structure
- Package aes_mon_pkg holds:
  - State enum.
  - PKT_HDR = 8'hA5.
  - PKT_LEN = 34.
  - Status-byte bit positions.
- Sub-module aes_mon_tx_serializer:
  - Loads the 272-bit packet in one cycle.
  - Shifts out bytes under valid/ready with a 6-bit index.
  - Reports last-byte-accepted.
- The top holds the edge detect, FSM, captures, counters and flags.

## Test plan
- FIPS-197 vector:
  - Stimulus: data_out=69c4e0d86a7b0430d8cdb78070b4c55a at enc_done, exp_enc equal; dec capture with exp_dec equal.
  - Response: match pulse, pass_cnt=1, packet A5 01 69 c4 … 5a followed by 16 dec bytes.
- Decrypt mismatch:
  - Stimulus: exp_dec differs from the dec capture in bit 0.
  - Response: mismatch pulse, fail_cnt=1, status byte 0x00.
- Back-pressure:
  - Stimulus: tx_ready toggled 1-0-0-1 throughout.
  - Response: 34 bytes in order, tx_data stable during stalls, no byte lost or duplicated.
- Protocol errors:
  - dec_done in IDLE: orphan=1, dec_q unchanged.
  - Second enc_done during WAIT_DEC: overrun=1, cipher_q unchanged.
  - Next packet status byte shows 0x06 plus the match bit.
- Held pulse:
  - Stimulus: enc_done held 8 cycles, then dec_done held 8 cycles.
  - Response: exactly one compare, pass_cnt incremented by 1.
- Reset and saturation:
  - Stimulus: rst asserted mid-STREAM (byte 10).
  - Response: tx_valid=0 and busy=0 immediately.
  - Stimulus: CNT_W=2 with 5 passes.
  - Response: pass_cnt=3.

Source files
------------

// File: rtl/aes_mon_pkg.sv
// aes_mon_pkg: shared types and constants for the AES result monitor.
//   aes_mon_state_e : monitor FSM states
//   PKT_HDR/PKT_LEN : result packet framing (header byte, length in bytes)
//   STS_*           : bit positions inside the packet status byte
//   status_byte()   : assembles the status byte from the flag values
package aes_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitDec,
    StCompare,
    StStream
  } aes_mon_state_e;

  localparam logic [7:0]  PKT_HDR = 8'hA5;
  localparam int unsigned PKT_LEN = 34;
  localparam int unsigned PKT_W   = PKT_LEN * 8;
  localparam int unsigned IDX_W   = 6;

  localparam int unsigned STS_MATCH   = 0;
  localparam int unsigned STS_ORPHAN  = 1;
  localparam int unsigned STS_OVERRUN = 2;

  function automatic logic [7:0] status_byte(logic overrun, logic orphan, logic match);
    logic [7:0] sts;
    sts              = '0;
    sts[STS_OVERRUN] = overrun;
    sts[STS_ORPHAN]  = orphan;
    sts[STS_MATCH]   = match;
    return sts;
  endfunction

endpackage

// File: rtl/aes_result_monitor_if.sv
// aes_result_monitor_if: byte-wide valid/ready stream toward a UART/debug sink.
//   tx_data  : packet byte
//   tx_valid : tx_data valid
//   tx_ready : sink accepts tx_data
// master = byte source (monitor), slave = byte sink.
interface aes_result_monitor_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/aes_mon_tx_serializer.sv
// aes_mon_tx_serializer: loads a whole result packet in one cycle and shifts it out
// most-significant byte first under valid/ready.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : load pkt_i and start sending (only pulsed while idle)
//   pkt_i    : packet, byte 0 in [PKT_W-1 -: 8]
//   last_o   : final byte accepted this cycle
//   tx_io    : byte stream source
module aes_mon_tx_serializer
  import aes_mon_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [PKT_W-1:0]     pkt_i,
  output logic                 last_o,
  aes_result_monitor_if.master tx_io
);

  logic [PKT_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             accept;
  logic             at_last;

  assign accept  = valid_q & tx_io.tx_ready;
  assign at_last = (idx_q == IDX_W'(PKT_LEN - 1));

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      shreg_d = pkt_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      // Current byte always sits at the top; stalls leave the register untouched.
      shreg_d = shreg_q << 8;
      if (at_last) begin
        idx_d   = '0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign tx_io.tx_data  = shreg_q[PKT_W-1 -: 8];
  assign tx_io.tx_valid = valid_q;
  assign last_o         = accept & at_last;

endmodule

// File: rtl/aes_result_monitor.sv
// aes_result_monitor: captures the SPI AES master's encrypt and decrypt results on the
// rising edges of enc_done/dec_done, compares the pair with expected vectors, keeps
// saturating pass/fail counters and sticky protocol-error flags, and optionally streams
// a 34-byte result packet (A5, status, cipher[127:0], dec[127:0]).
//   clk, rst               : master's undivided clock, asynchronous active-high reset
//   enc_done_i, dec_done_i : done levels from the master (may be held many cycles)
//   data_out_i             : master result bus
//   exp_enc_i, exp_dec_i   : expected vectors, sampled with the matching capture
//   cipher_q_o, dec_q_o    : captured results
//   match_o, mismatch_o    : one-cycle compare outcome
//   pass_cnt_o, fail_cnt_o : saturating outcome counters
//   overrun_o, orphan_o    : sticky protocol-error flags
//   busy_o                 : FSM not idle
//   tx_io                  : packet byte stream
module aes_result_monitor
  import aes_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter bit          STREAM_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enc_done_i,
  input  logic                 dec_done_i,
  input  logic [127:0]         data_out_i,
  input  logic [127:0]         exp_enc_i,
  input  logic [127:0]         exp_dec_i,
  output logic [127:0]         cipher_q_o,
  output logic [127:0]         dec_q_o,
  output logic                 match_o,
  output logic                 mismatch_o,
  output logic [CNT_W-1:0]     pass_cnt_o,
  output logic [CNT_W-1:0]     fail_cnt_o,
  output logic                 overrun_o,
  output logic                 orphan_o,
  output logic                 busy_o,
  aes_result_monitor_if.master tx_io
);

  aes_mon_state_e   state_q, state_d;
  logic             enc_prev_q, dec_prev_q;
  logic             enc_rise, dec_rise;
  logic [127:0]     cipher_q, dec_q, exp_enc_q, exp_dec_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic             overrun_q, orphan_q;
  logic             results_eq;
  logic             cap_enc, cap_dec, set_overrun, set_orphan, load;
  logic             tx_last;
  logic [PKT_W-1:0] pkt;

  // A held done level yields a single event.
  assign enc_rise   = enc_done_i & ~enc_prev_q;
  assign dec_rise   = dec_done_i & ~dec_prev_q;
  assign results_eq = (cipher_q == exp_enc_q) && (dec_q == exp_dec_q);

  // Flags are sampled in the COMPARE cycle, when the packet is loaded, so later errors
  // cannot change a packet already in flight.
  assign pkt = {PKT_HDR, status_byte(overrun_q, orphan_q, results_eq), cipher_q, dec_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (enc_rise) state_d = StWaitDec;
      StWaitDec: if (dec_rise) state_d = StCompare;
      StCompare: state_d = STREAM_EN ? StStream : StIdle;
      StStream:  if (tx_last) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o      = 1'b0;
    match_o     = 1'b0;
    mismatch_o  = 1'b0;
    cap_enc     = 1'b0;
    cap_dec     = 1'b0;
    set_overrun = 1'b0;
    set_orphan  = 1'b0;
    load        = 1'b0;
    case (state_q)
      StIdle: begin
        // Simultaneous edges: enc wins, dec is reported as an orphan.
        cap_enc    = enc_rise;
        set_orphan = dec_rise;
      end
      StWaitDec: begin
        busy_o      = 1'b1;
        cap_dec     = dec_rise;
        set_overrun = enc_rise;
      end
      StCompare: begin
        busy_o      = 1'b1;
        match_o     = results_eq;
        mismatch_o  = ~results_eq;
        load        = STREAM_EN;
        set_overrun = enc_rise;
        set_orphan  = dec_rise;
      end
      StStream: begin
        busy_o      = 1'b1;
        set_overrun = enc_rise;
        set_orphan  = dec_rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      cipher_q   <= '0;
      dec_q      <= '0;
      exp_enc_q  <= '0;
      exp_dec_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      overrun_q  <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      enc_prev_q <= enc_done_i;
      dec_prev_q <= dec_done_i;
      if (cap_enc) begin
        cipher_q  <= data_out_i;
        exp_enc_q <= exp_enc_i;
      end
      if (cap_dec) begin
        dec_q     <= data_out_i;
        exp_dec_q <= exp_dec_i;
      end
      if (set_overrun) overrun_q <= 1'b1;
      if (set_orphan)  orphan_q  <= 1'b1;
      if (match_o && (pass_q != '1))    pass_q <= pass_q + CNT_W'(1);
      if (mismatch_o && (fail_q != '1)) fail_q <= fail_q + CNT_W'(1);
    end
  end

  aes_mon_tx_serializer u_tx_serializer (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .pkt_i  (pkt),
    .last_o (tx_last),
    .tx_io  (tx_io)
  );

  assign cipher_q_o = cipher_q;
  assign dec_q_o    = dec_q;
  assign pass_cnt_o = pass_q;
  assign fail_cnt_o = fail_q;
  assign overrun_o  = overrun_q;
  assign orphan_o   = orphan_q;

endmodule

// File: tb/tb_aes_result_monitor.sv
// Bench for aes_result_monitor: directed scenarios with random vectors, checked against a
// transaction-level model (captured values, counters, flags, expected byte queue).
// DUT A: CNT_W=16, streaming on. DUT B: CNT_W=2, streaming off (saturation, turnaround).
module tb_aes_result_monitor;

  logic clk = 1'b0;
  logic rst;
  logic enc_a, dec_a, enc_b, dec_b;
  logic [127:0] data_out, exp_enc, exp_dec;

  logic [127:0] cipher_a, decq_a, cipher_b, decq_b;
  logic         match_a, mismatch_a, overrun_a, orphan_a, busy_a;
  logic         match_b, mismatch_b, overrun_b, orphan_b, busy_b;
  logic [15:0]  pass_a, fail_a;
  logic [1:0]   pass_b, fail_b;

  aes_result_monitor_if tx_a ();
  aes_result_monitor_if tx_b ();

  aes_result_monitor #(.CNT_W(16), .STREAM_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .enc_done_i(enc_a), .dec_done_i(dec_a), .data_out_i(data_out),
    .exp_enc_i(exp_enc), .exp_dec_i(exp_dec), .cipher_q_o(cipher_a), .dec_q_o(decq_a),
    .match_o(match_a), .mismatch_o(mismatch_a), .pass_cnt_o(pass_a), .fail_cnt_o(fail_a),
    .overrun_o(overrun_a), .orphan_o(orphan_a), .busy_o(busy_a), .tx_io(tx_a)
  );

  aes_result_monitor #(.CNT_W(2), .STREAM_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .enc_done_i(enc_b), .dec_done_i(dec_b), .data_out_i(data_out),
    .exp_enc_i(exp_enc), .exp_dec_i(exp_dec), .cipher_q_o(cipher_b), .dec_q_o(decq_b),
    .match_o(match_b), .mismatch_o(mismatch_b), .pass_cnt_o(pass_b), .fail_cnt_o(fail_b),
    .overrun_o(overrun_b), .orphan_o(orphan_b), .busy_o(busy_b), .tx_io(tx_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned stream_start = 0;
  int unsigned bp_cnt = 0;
  logic bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  logic [7:0] rx_q[$];
  logic [7:0] exp_pkt[$];

  // Reference model state
  logic [127:0] m_cipher, m_exp_enc, m_dec;
  int m_pass, m_fail;
  logic m_ovr, m_orph;
  bit m_armed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte collector plus stall-stability check on the sink side.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst && prev_stall) chk("stall_hold", {tx_a.tx_valid, tx_a.tx_data}, {1'b1, prev_data});
    prev_stall <= tx_a.tx_valid && !tx_a.tx_ready && !rst;
    prev_data  <= tx_a.tx_data;
    if (!rst && tx_a.tx_valid && tx_a.tx_ready) rx_q.push_back(tx_a.tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bp_cnt++;
    tx_a.tx_ready = bp_mode ? bp_pat[2'(bp_cnt % 4)] : 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_enc(input logic [127:0] d, input logic [127:0] e, input int hold);
    data_out = d;
    exp_enc  = e;
    enc_a    = 1'b1;
    tick();
    if (!m_armed) begin
      m_cipher  = d;
      m_exp_enc = e;
      m_armed   = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
    chk("enc_cipher", cipher_a, m_cipher);
    chk("enc_overrun", overrun_a, m_ovr);
    chk("enc_busy", busy_a, 1'b1);
    repeat (hold - 1) tick();
    enc_a = 1'b0;
    tick();
  endtask

  task automatic send_dec(input logic [127:0] d, input logic [127:0] e, input int hold);
    logic eq;
    data_out = d;
    exp_dec  = e;
    dec_a    = 1'b1;
    tick();
    if (m_armed) begin
      m_armed = 1'b0;
      m_dec   = d;
      eq      = (m_cipher == m_exp_enc) && (d == e);
      chk("cmp_match", match_a, eq);
      chk("cmp_mismatch", mismatch_a, !eq);
      chk("cmp_decq", decq_a, m_dec);
      exp_pkt.delete();
      exp_pkt.push_back(8'hA5);
      exp_pkt.push_back({5'b0, m_ovr, m_orph, eq});
      for (int i = 15; i >= 0; i--) exp_pkt.push_back(m_cipher[i*8 +: 8]);
      for (int i = 15; i >= 0; i--) exp_pkt.push_back(m_dec[i*8 +: 8]);
      if (hold == 1) dec_a = 1'b0;
      tick();
      stream_start = cyc;
      if (eq) m_pass = (m_pass == 65535) ? m_pass : m_pass + 1;
      else    m_fail = (m_fail == 65535) ? m_fail : m_fail + 1;
      chk("pulse_end_match", match_a, 1'b0);
      chk("pulse_end_mismatch", mismatch_a, 1'b0);
      chk("tx_valid_rise", tx_a.tx_valid, 1'b1);
      chk("pass_cnt", pass_a, 128'(m_pass));
      chk("fail_cnt", fail_a, 128'(m_fail));
      for (int i = 2; i < hold; i++) tick();
      dec_a = 1'b0;
    end else begin
      m_orph = 1'b1;
      chk("orphan_flag", orphan_a, 1'b1);
      chk("orphan_decq", decq_a, m_dec);
      repeat (hold - 1) tick();
      dec_a = 1'b0;
      tick();
    end
  endtask

  task automatic finish_packet();
    for (int i = 0; i < 400 && busy_a === 1'b1; i++) tick();
    chk("pkt_done_busy", busy_a, 1'b0);
    chk("pkt_done_valid", tx_a.tx_valid, 1'b0);
    if (!bp_mode) chk("stream_cycles", 128'(cyc - stream_start), 128'd34);
    chk("pkt_len", 128'(rx_q.size()), 128'(exp_pkt.size()));
    for (int i = 0; i < exp_pkt.size(); i++) begin
      if (i < rx_q.size()) chk($sformatf("pkt[%0d]", i), rx_q[i], exp_pkt[i]);
    end
    rx_q.delete();
  endtask

  task automatic model_reset();
    m_cipher = '0; m_exp_enc = '0; m_dec = '0;
    m_pass = 0; m_fail = 0; m_ovr = 1'b0; m_orph = 1'b0; m_armed = 1'b0;
  endtask

  initial begin
    logic [127:0] a, b, c;
    rst = 1'b1;
    enc_a = 1'b0; dec_a = 1'b0; enc_b = 1'b0; dec_b = 1'b0;
    data_out = '0; exp_enc = '0; exp_dec = '0;
    tx_a.tx_ready = 1'b1;
    tx_b.tx_ready = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("rst_cipher", cipher_a, '0);
    chk("rst_decq", decq_a, '0);
    chk("rst_cnts", {pass_a, fail_a}, '0);
    chk("rst_flags", {overrun_a, orphan_a, busy_a, match_a, mismatch_a}, '0);
    chk("rst_tx_valid", tx_a.tx_valid, 1'b0);
    rst = 1'b0;
    tick();

    // FIPS-197 vector
    send_enc(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1);
    send_dec(128'h00112233445566778899aabbccddeeff, 128'h00112233445566778899aabbccddeeff, 1);
    finish_packet();

    // Decrypt mismatch in bit 0
    a = rnd128(); c = rnd128();
    send_enc(a, a, 1);
    send_dec(c, c ^ 128'h1, 1);
    finish_packet();

    // Back-pressure 1-0-0-1
    bp_mode = 1'b1;
    a = rnd128(); c = rnd128();
    send_enc(a, a, 1);
    send_dec(c, c, 1);
    finish_packet();
    bp_mode = 1'b0;
    tick();

    // Protocol errors: orphan dec in IDLE, second enc while waiting for dec
    send_dec(rnd128(), rnd128(), 1);
    a = rnd128(); b = rnd128(); c = rnd128();
    send_enc(a, a, 1);
    send_enc(b, b, 1);
    send_dec(c, c, 1);
    finish_packet();

    // Held done levels
    a = rnd128(); c = rnd128();
    send_enc(a, a, 8);
    send_dec(c, c, 8);
    finish_packet();

    // Reset mid-STREAM
    a = rnd128(); c = rnd128();
    send_enc(a, a, 1);
    send_dec(c, c, 1);
    for (int i = 0; i < 100 && rx_q.size() < 10; i++) tick();
    chk("bytes_before_rst", 128'(rx_q.size()), 128'd10);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", tx_a.tx_valid, 1'b0);
    chk("rst_mid_busy", busy_a, 1'b0);
    chk("rst_mid_state", {pass_a, fail_a, overrun_a, orphan_a}, '0);
    chk("rst_mid_cipher", cipher_a, '0);
    model_reset();
    tick();
    rst = 1'b0;
    rx_q.delete();
    tick();
    a = rnd128(); c = rnd128();
    send_enc(a, a, 1);
    send_dec(c, c, 1);
    finish_packet();

    // DUT B: 2-bit counter saturation at minimum (3-cycle) turnaround
    for (int i = 1; i <= 5; i++) begin
      a = rnd128();
      data_out = a; exp_enc = a; enc_b = 1'b1;
      tick();
      chk("b_cipher", cipher_b, a);
      enc_b = 1'b0;
      c = rnd128();
      data_out = c; exp_dec = c; dec_b = 1'b1;
      tick();
      chk("b_match", {match_b, mismatch_b, busy_b}, 3'b101);
      dec_b = 1'b0;
      tick();
      chk("b_pass_cnt", pass_b, 128'((i > 3) ? 3 : i));
      chk("b_idle", busy_b, 1'b0);
    end
    chk("b_no_stream", tx_b.tx_valid, 1'b0);
    chk("b_flags", {fail_b, overrun_b, orphan_b, decq_b == c}, 5'b00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
